// File: rtl/pll_lock_supervisor.sv
`default_nettype none
// ============================================================================
//  Module  : pll_lock_supervisor
//  Purpose : Managed bring-up of one PLL from the free-running board clock.
//            Pulses the PLL reset, waits for lock with a timeout and a bounded
//            number of retries, debounces lock, then releases NUM_DOMAINS
//            downstream resets one after another. A lock loss after release
//            re-asserts every domain reset, is counted, and triggers an
//            automatic relock.
//  Ports   : clk            free-running reference clock (PLL clkin source)
//            rst            synchronous active-high reset
//            pll_lock_i     PLL LOCK, asynchronous to clk
//            force_relock_i single-cycle request to restart the PLL sequence
//            pll_rst_o      PLL RESET, active-high
//            domain_rst_o   per-domain reset requests, active-high
//            ready_o        all domains released and PLL locked
//            fail_o         MAX_RETRY consecutive lock timeouts reached
//            loss_cnt_o     saturating count of lock losses after release
//  Revision: 1.0  initial release
// ============================================================================
module pll_lock_supervisor #(
    parameter int NUM_DOMAINS      = 2,
    parameter int RST_PULSE_CYC    = 16,
    parameter int LOCK_TIMEOUT_CYC = 2500000,
    parameter int LOCK_STABLE_CYC  = 1024,
    parameter int STAGGER_CYC      = 64,
    parameter int MAX_RETRY        = 3,
    parameter int CNT_W            = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   pll_lock_i,
    input  logic                   force_relock_i,
    output logic                   pll_rst_o,
    output logic [NUM_DOMAINS-1:0] domain_rst_o,
    output logic                   ready_o,
    output logic                   fail_o,
    output logic [CNT_W-1:0]       loss_cnt_o
);

    // One shared phase timer covers the pulse, the lock wait, the debounce
    // window and the release stagger, so it is sized for the longest of them.
    localparam int REL_CYC  = NUM_DOMAINS * STAGGER_CYC;
    localparam int MAX_A    = (RST_PULSE_CYC > LOCK_TIMEOUT_CYC) ? RST_PULSE_CYC : LOCK_TIMEOUT_CYC;
    localparam int MAX_B    = (MAX_A > LOCK_STABLE_CYC) ? MAX_A : LOCK_STABLE_CYC;
    localparam int TMR_MAX  = (MAX_B > REL_CYC) ? MAX_B : REL_CYC;
    localparam int TMR_W    = $clog2(TMR_MAX + 1);
    localparam int RTY_W    = $clog2(MAX_RETRY + 1);

    localparam logic [TMR_W-1:0] PULSE_LAST   = TMR_W'(RST_PULSE_CYC - 1);
    localparam logic [TMR_W-1:0] TIMEOUT_LAST = TMR_W'(LOCK_TIMEOUT_CYC - 1);
    localparam logic [TMR_W-1:0] STABLE_LAST  = TMR_W'(LOCK_STABLE_CYC - 1);
    localparam logic [TMR_W-1:0] REL_LAST     = TMR_W'(REL_CYC - 1);
    localparam logic [RTY_W-1:0] RETRY_LAST   = RTY_W'(MAX_RETRY - 1);
    localparam logic [CNT_W-1:0] LOSS_MAX     = '1;

    typedef enum logic [2:0] {
        S_RESET_PLL = 3'd0,
        S_WAIT_LOCK = 3'd1,
        S_STABLE    = 3'd2,
        S_RELEASE   = 3'd3,
        S_RUN       = 3'd4,
        S_FAIL      = 3'd5
    } state_t;

    state_t                 state;
    state_t                 state_next;
    logic [TMR_W-1:0]       timer;
    logic [TMR_W-1:0]       timer_next;
    logic [RTY_W-1:0]       retry;
    logic [RTY_W-1:0]       retry_next;
    logic [CNT_W-1:0]       loss_next;
    logic [NUM_DOMAINS-1:0] dom_next;
    logic                   lock_meta;
    logic                   lock_s;

    // ------------------------------------------------------------------
    // Next-state, counters and next output values
    // ------------------------------------------------------------------
    always_comb begin
        state_next = state;
        timer_next = timer;
        retry_next = retry;
        loss_next  = loss_cnt_o;

        case (state)
            S_RESET_PLL: begin
                if (timer == PULSE_LAST) begin
                    state_next = S_WAIT_LOCK;
                    timer_next = '0;
                end else begin
                    timer_next = timer + TMR_W'(1);
                end
            end
            S_WAIT_LOCK: begin
                if (lock_s) begin
                    state_next = S_STABLE;
                    timer_next = '0;
                end else if (timer == TIMEOUT_LAST) begin
                    retry_next = retry + RTY_W'(1);
                    timer_next = '0;
                    state_next = (retry == RETRY_LAST) ? S_FAIL : S_RESET_PLL;
                end else begin
                    timer_next = timer + TMR_W'(1);
                end
            end
            S_STABLE: begin
                // A dropout here is a debounce failure, not a loss event.
                if (!lock_s) begin
                    state_next = S_WAIT_LOCK;
                    timer_next = '0;
                end else if (timer == STABLE_LAST) begin
                    state_next = S_RELEASE;
                    timer_next = '0;
                end else begin
                    timer_next = timer + TMR_W'(1);
                end
            end
            S_RELEASE, S_RUN: begin
                if (!lock_s) begin
                    state_next = S_RESET_PLL;
                    timer_next = '0;
                    loss_next  = (loss_cnt_o == LOSS_MAX) ? loss_cnt_o : loss_cnt_o + CNT_W'(1);
                end else if (state == S_RELEASE) begin
                    if (timer == REL_LAST) begin
                        state_next = S_RUN;
                        timer_next = '0;
                        retry_next = '0;
                    end else begin
                        timer_next = timer + TMR_W'(1);
                    end
                end
            end
            S_FAIL: begin
                state_next = S_FAIL;
            end
            default: begin
                state_next = S_RESET_PLL;
                timer_next = '0;
            end
        endcase

        // A relock request overrides everything above, including a loss
        // seen in the same cycle, so the loss counter is left untouched.
        if (force_relock_i) begin
            state_next = S_RESET_PLL;
            timer_next = '0;
            retry_next = '0;
            loss_next  = loss_cnt_o;
        end

        // Domain i is released once (i+1)*STAGGER_CYC cycles have elapsed
        // in RELEASE; timer_next is that elapsed count after this edge.
        dom_next = '1;
        for (int i = 0; i < NUM_DOMAINS; i++) begin
            if (state_next == S_RUN) begin
                dom_next[i] = 1'b0;
            end else if (state_next == S_RELEASE && int'(timer_next) >= (i + 1) * STAGGER_CYC) begin
                dom_next[i] = 1'b0;
            end
        end
    end

    // ------------------------------------------------------------------
    // State, counters, synchroniser and registered outputs
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= S_RESET_PLL;
            timer        <= '0;
            retry        <= '0;
            lock_meta    <= 1'b0;
            lock_s       <= 1'b0;
            pll_rst_o    <= 1'b1;
            domain_rst_o <= '1;
            ready_o      <= 1'b0;
            fail_o       <= 1'b0;
            loss_cnt_o   <= '0;
        end else begin
            state        <= state_next;
            timer        <= timer_next;
            retry        <= retry_next;
            lock_meta    <= pll_lock_i;
            lock_s       <= lock_meta;
            pll_rst_o    <= (state_next == S_RESET_PLL) || (state_next == S_FAIL);
            domain_rst_o <= dom_next;
            ready_o      <= (state_next == S_RUN);
            fail_o       <= (state_next == S_FAIL);
            loss_cnt_o   <= loss_next;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_pll_lock_supervisor.sv
`default_nettype none
// ============================================================================
//  Module  : tb_pll_lock_supervisor
//  Purpose : Self-checking bench for pll_lock_supervisor. Directed scenarios
//            followed by randomized lock/relock/reset traffic, with every
//            cycle compared against a phase/elapsed-time reference model.
//  Revision: 1.0  initial release
// ============================================================================
module tb_pll_lock_supervisor;

    localparam int ND   = 3;
    localparam int PULSE = 4;
    localparam int TMO  = 100;
    localparam int STB  = 16;
    localparam int STG  = 8;
    localparam int MAXR = 2;
    localparam int CW   = 2;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          pll_lock_i = 1'b0;
    logic          force_relock_i = 1'b0;
    logic          pll_rst_o;
    logic [ND-1:0] domain_rst_o;
    logic          ready_o;
    logic          fail_o;
    logic [CW-1:0] loss_cnt_o;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    pll_lock_supervisor #(
        .NUM_DOMAINS      (ND),
        .RST_PULSE_CYC    (PULSE),
        .LOCK_TIMEOUT_CYC (TMO),
        .LOCK_STABLE_CYC  (STB),
        .STAGGER_CYC      (STG),
        .MAX_RETRY        (MAXR),
        .CNT_W            (CW)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .pll_lock_i     (pll_lock_i),
        .force_relock_i (force_relock_i),
        .pll_rst_o      (pll_rst_o),
        .domain_rst_o   (domain_rst_o),
        .ready_o        (ready_o),
        .fail_o         (fail_o),
        .loss_cnt_o     (loss_cnt_o)
    );

    always #5 clk = ~clk;

    // ------------------------------------------------------------------
    // Reference model: which phase the bring-up is in and how many cycles
    // have elapsed in it; outputs follow directly from those two facts.
    // ------------------------------------------------------------------
    typedef enum int {PH_PULSE, PH_WAIT, PH_STABLE, PH_REL, PH_RUN, PH_FAIL} phase_t;

    phase_t m_phase = PH_PULSE;
    int     m_age   = 0;
    int     m_retry = 0;
    int     m_loss  = 0;
    bit     m_hist1 = 1'b0;  // pin one edge ago
    bit     m_hist2 = 1'b0;  // pin two edges ago: the lock the design acts on

    function automatic void m_enter(phase_t p);
        m_phase = p;
        m_age   = 0;
    endfunction

    function automatic void model_edge(bit r, bit fr, bit pin);
        bit locked;
        locked = m_hist2;
        if (r) begin
            m_enter(PH_PULSE);
            m_retry = 0;
            m_loss  = 0;
            m_hist1 = 1'b0;
            m_hist2 = 1'b0;
            return;
        end
        m_hist2 = m_hist1;
        m_hist1 = pin;
        if (fr) begin
            m_enter(PH_PULSE);
            m_retry = 0;
            return;
        end
        m_age++;
        case (m_phase)
            PH_PULSE:  if (m_age == PULSE) m_enter(PH_WAIT);
            PH_WAIT: begin
                if (locked) m_enter(PH_STABLE);
                else if (m_age == TMO) begin
                    m_retry++;
                    m_enter((m_retry == MAXR) ? PH_FAIL : PH_PULSE);
                end
            end
            PH_STABLE: begin
                if (!locked) m_enter(PH_WAIT);
                else if (m_age == STB) m_enter(PH_REL);
            end
            PH_REL, PH_RUN: begin
                if (!locked) begin
                    if (m_loss < (1 << CW) - 1) m_loss++;
                    m_enter(PH_PULSE);
                end else if (m_phase == PH_REL && m_age == ND * STG) begin
                    m_retry = 0;
                    m_enter(PH_RUN);
                end
            end
            default: ;
        endcase
    endfunction

    function automatic logic [ND+CW+2:0] model_vec();
        logic [ND-1:0] d;
        for (int i = 0; i < ND; i++)
            d[i] = !(m_phase == PH_RUN || (m_phase == PH_REL && m_age >= (i + 1) * STG));
        return {m_phase == PH_PULSE || m_phase == PH_FAIL, d,
                m_phase == PH_RUN, m_phase == PH_FAIL, CW'(m_loss)};
    endfunction

    // ------------------------------------------------------------------
    // Checking and stimulus helpers
    // ------------------------------------------------------------------
    task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic tick(bit lk, bit fr);
        pll_lock_i     = lk;
        force_relock_i = fr;
        @(posedge clk);
        cyc++;
        model_edge(rst, fr, lk);
        #1;
        check("cycle_vs_model", {pll_rst_o, domain_rst_o, ready_o, fail_o, loss_cnt_o}, model_vec());
    endtask

    int t_fall[ND];
    int t_ready;

    // Hold lock high until ready_o, recording when each domain reset falls.
    task automatic run_until_ready();
        for (int i = 0; i < ND; i++) t_fall[i] = -1;
        t_ready = -1;
        for (int n = 0; n < 400 && !ready_o; n++) begin
            tick(1'b1, 1'b0);
            for (int i = 0; i < ND; i++)
                if (t_fall[i] < 0 && !domain_rst_o[i]) t_fall[i] = cyc;
            if (ready_o) t_ready = cyc;
        end
        check("ready_reached", ready_o, 1);
    endtask

    task automatic count_pulse(string tag);
        int n;
        n = 0;
        do begin
            tick(1'b0, 1'b0);
            n++;
        end while (pll_rst_o && n < 50);
        check(tag, n, PULSE);
    endtask

    task automatic drop_lock_and_check(int exp_loss);
        repeat (3) tick(1'b0, 1'b0);
        check("loss_dom_rst", domain_rst_o, 3'b111);
        check("loss_ready", ready_o, 0);
        check("loss_count", loss_cnt_o, exp_loss);
    endtask

    int k, f, fall1, rise2, fall2, tfail;
    bit prev, rlk;

    initial begin
        // ---------------- reset state ----------------
        rst = 1'b1;
        repeat (3) tick(1'b0, 1'b0);
        check("reset_outputs", {pll_rst_o, domain_rst_o, ready_o, fail_o, loss_cnt_o},
              {1'b1, 3'b111, 1'b0, 1'b0, 2'b00});
        rst = 1'b0;

        // ---------------- nominal bring-up ----------------
        count_pulse("pulse_width_nominal");
        repeat (9) tick(1'b0, 1'b0);
        k = cyc + 1;
        run_until_ready();
        for (int i = 0; i < ND; i++)
            check("release_time", t_fall[i] - k, 2 + STB + (i + 1) * STG);
        check("ready_with_last", t_ready, t_fall[ND-1]);
        check("nominal_fail", fail_o, 0);

        // ---------------- stable debounce ----------------
        tick(1'b0, 1'b1);
        count_pulse("pulse_width_relock");
        repeat (10) tick(1'b1, 1'b0);
        tick(1'b0, 1'b0);
        k = cyc + 1;
        run_until_ready();
        check("debounce_release", t_fall[0] - k, 2 + STB + STG);
        check("debounce_loss", loss_cnt_o, 0);

        // ---------------- losses in RUN / simultaneous force ----------------
        for (int j = 1; j <= 2; j++) begin
            drop_lock_and_check(j);
            run_until_ready();
            check("relock_stagger01", t_fall[1] - t_fall[0], STG);
            check("relock_stagger12", t_fall[2] - t_fall[1], STG);
        end
        tick(1'b0, 1'b0);
        tick(1'b0, 1'b0);
        tick(1'b0, 1'b1);
        check("simul_loss_count", loss_cnt_o, 2);
        check("simul_pll_rst", pll_rst_o, 1);
        check("simul_dom_rst", domain_rst_o, 3'b111);
        run_until_ready();
        for (int j = 3; j <= 4; j++) begin
            drop_lock_and_check(3);
            run_until_ready();
        end

        // ---------------- timeout to FAIL ----------------
        tick(1'b0, 1'b1);
        f = cyc; fall1 = -1; rise2 = -1; fall2 = -1; tfail = -1;
        for (int n = 0; n < 300 && !fail_o; n++) begin
            prev = pll_rst_o;
            tick(1'b0, 1'b0);
            if (prev && !pll_rst_o) begin
                if (fall1 < 0) fall1 = cyc; else fall2 = cyc;
            end
            if (!prev && pll_rst_o && !fail_o) rise2 = cyc;
            if (fail_o) tfail = cyc;
        end
        check("tmo_pulse1", fall1 - f, PULSE);
        check("tmo_wait1", rise2 - fall1, TMO);
        check("tmo_pulse2", fall2 - rise2, PULSE);
        check("tmo_wait2", tfail - fall2, TMO);
        repeat (20) tick(1'b0, 1'b0);
        check("fail_held", {fail_o, pll_rst_o, domain_rst_o, ready_o}, {1'b1, 1'b1, 3'b111, 1'b0});
        tick(1'b0, 1'b1);
        check("fail_cleared", fail_o, 0);
        count_pulse("pulse_after_fail");

        // ---------------- reset mid-RELEASE ----------------
        tick(1'b1, 1'b1);
        for (int n = 0; n < 200 && domain_rst_o[0]; n++) tick(1'b1, 1'b0);
        check("dom0_released", domain_rst_o[0], 0);
        rst = 1'b1;
        tick(1'b1, 1'b0);
        check("reset_mid_release", {pll_rst_o, domain_rst_o, ready_o, fail_o, loss_cnt_o},
              {1'b1, 3'b111, 1'b0, 1'b0, 2'b00});
        rst = 1'b0;

        // ---------------- randomized traffic ----------------
        rlk = 1'b0;
        for (int seg = 0; seg < 120; seg++) begin
            int len;
            case ($urandom_range(0, 2))
                0:       len = $urandom_range(1, 5);
                1:       len = $urandom_range(10, 40);
                default: len = $urandom_range(60, 200);
            endcase
            rlk = ~rlk;
            for (int n = 0; n < len; n++) begin
                rst = ($urandom_range(0, 1999) == 0);
                tick(rlk, $urandom_range(0, 299) == 0);
            end
            rst = 1'b0;
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
